// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, controller states, default latencies.
// Imported by the E/D-stage decoder as well as by the unit itself.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  // Counter must hold the longer latency; never narrower than 4 bits.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    int w;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w = $clog2(m + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational mult/div datapath: {hi,lo} = product, or {remainder, quotient} for divides.
// No state, no latency; o_div0 flags a divide whose divisor is zero.
module mdu_alu
  import mdu_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div0
);

  logic        w_sgn;
  logic        w_is_div;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_sgn    = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_is_div = (i_op == MD_DIV) || (i_op == MD_DIVU);

  // Low 64 bits of the extended product are exact for both signed and unsigned.
  assign w_ext_a = {{32{w_sgn & i_a[31]}}, i_a};
  assign w_ext_b = {{32{w_sgn & i_b[31]}}, i_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Divide on magnitudes, then restore signs: truncation toward zero, remainder follows dividend.
  assign w_neg_a = w_sgn & i_a[31];
  assign w_neg_b = w_sgn & i_b[31];
  assign w_mag_a = w_neg_a ? (~i_a + 32'd1) : i_a;
  assign w_mag_b = w_neg_b ? (~i_b + 32'd1) : i_b;
  assign w_den   = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq    = w_mag_a / w_den;
  assign w_ur    = w_mag_a % w_den;
  assign w_quo   = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem   = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  assign o_res  = w_is_div ? {w_rem, w_quo} : w_prod;
  assign o_div0 = w_is_div && (i_b == 32'd0);

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO; result lands MULT_CYCLES/DIV_CYCLES after the start.
// Starts are ignored while busy; MdStall holds HI/LO users in D until the result is written.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MdStart,
  input  logic [2:0]  E_MdOp,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic        D_MdUse,
  output logic        Busy,
  output logic        MdStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic        r_busy;
  md_op_e      r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  md_op_e      w_op;
  logic [63:0] w_res;
  logic        w_div0;

  assign w_op = md_op_e'(E_MdOp);

  mdu_alu u_alu (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_res  (w_res),
    .o_div0 (w_div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_op    <= MD_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (E_MdStart) begin
            case (w_op)
              MD_MULT, MD_MULTU: begin
                r_op    <= w_op;
                r_a     <= E_RD1;
                r_b     <= E_RD2;
                r_cnt   <= CW'(MULT_CYCLES);
                r_state <= MD_BUSY;
                r_busy  <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                r_op    <= w_op;
                r_a     <= E_RD1;
                r_b     <= E_RD2;
                r_cnt   <= CW'(DIV_CYCLES);
                r_state <= MD_BUSY;
                r_busy  <= 1'b1;
              end
              MD_MTHI: r_hi <= E_RD1;
              MD_MTLO: r_lo <= E_RD1;
              default: ;
            endcase
          end
        end
        MD_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            // A zero divisor still burns the full latency but leaves HI/LO alone.
            if (!w_div0) begin
              r_hi <= w_res[63:32];
              r_lo <= w_res[31:0];
            end
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = r_busy;
  assign MdStall = D_MdUse & (r_busy | (E_MdStart & (E_MdOp <= 3'(MD_DIVU))));
  assign HI      = r_hi;
  assign LO      = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed test-plan sequences with literal expectations, then random traffic,
// all compared every cycle against a time-stamped behavioural model of HI/LO/Busy/MdStall.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        E_MdStart;
  logic [2:0]  E_MdOp;
  logic [31:0] E_RD1;
  logic [31:0] E_RD2;
  logic        D_MdUse;
  logic        Busy;
  logic        MdStall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MdStart (E_MdStart),
    .E_MdOp    (E_MdOp),
    .E_RD1     (E_RD1),
    .E_RD2     (E_RD2),
    .D_MdUse   (D_MdUse),
    .Busy      (Busy),
    .MdStall   (MdStall),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op records the cycle its result lands.
  bit          m_valid = 0;
  bit          m_active = 0;
  bit          m_wr = 0;
  int          m_done = 0;
  int          now = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [63:0] m_res = 0;

  function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          q;
    longint          r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return 64'd0;
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi     = 0;
      m_lo     = 0;
      m_active = 0;
      m_valid  = 1;
    end else if (m_active) begin
      if (now == m_done) begin
        if (m_wr) {m_hi, m_lo} = m_res;
        m_active = 0;
      end
    end else if (E_MdStart) begin
      if (E_MdOp <= 3'd3) begin
        m_res    = model_res(E_MdOp, E_RD1, E_RD2);
        m_wr     = !((E_MdOp >= 3'd2) && (E_RD2 == 32'd0));
        m_done   = now + ((E_MdOp < 3'd2) ? MC : DC);
        m_active = 1;
      end else if (E_MdOp == 3'd4) begin
        m_hi = E_RD1;
      end else if (E_MdOp == 3'd5) begin
        m_lo = E_RD1;
      end
    end
    now++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", Busy, m_active);
      chk("stall", MdStall, D_MdUse & (m_active | (E_MdStart & (E_MdOp <= 3'd3))));
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit use_md, output int nbusy, output int nstall);
    nbusy  = 0;
    nstall = 0;
    E_MdStart = 1;
    E_MdOp    = op;
    E_RD1     = a;
    E_RD2     = b;
    D_MdUse   = use_md;
    #1;
    if (MdStall) nstall++;
    @(posedge clk); #1;
    E_MdStart = 0;
    #1;
    while (Busy && nbusy < 64) begin
      nbusy++;
      if (MdStall) nstall++;
      @(posedge clk); #2;
    end
    if (nbusy >= 64) chk("busy_timeout", 32'(nbusy), 32'd0);
  endtask

  task automatic idle(input int n);
    E_MdStart = 0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int nb;
  int ns;
  int w;

  initial begin
    reset = 1; E_MdStart = 0; E_MdOp = 0; E_RD1 = 0; E_RD2 = 0; D_MdUse = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", Busy, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    reset = 0;
    #1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 0, nb, ns);
    chk("mult_cycles", nb, MC);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 0, nb, ns);
    chk("multu_cycles", nb, MC);
    chk("multu_hi", HI, 32'h1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 0, nb, ns);
    chk("div_cycles", nb, DC);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd2, 0, nb, ns);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    run_op(3'd4, 32'h1234, 32'h0, 0, nb, ns);
    chk("mthi_busy", nb, 0);
    chk("mthi_hi", HI, 32'h1234);
    run_op(3'd5, 32'h5678, 32'h0, 0, nb, ns);
    chk("mtlo_busy", nb, 0);
    chk("mtlo_lo", LO, 32'h5678);

    run_op(3'd3, 32'd5, 32'd0, 0, nb, ns);
    chk("div0_cycles", nb, DC);
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'h5678);

    run_op(3'd0, 32'd3, 32'd4, 1, nb, ns);
    chk("stall_cycles", ns, MC + 1);
    chk("stall_low", MdStall, 0);
    D_MdUse = 0;

    // Starts arriving mid-operation must be dropped.
    E_MdStart = 1; E_MdOp = 3'd0; E_RD1 = 32'd3; E_RD2 = 32'd5;
    @(posedge clk); #2;
    idle(2);
    E_MdStart = 1; E_MdOp = 3'd0; E_RD1 = 32'd7; E_RD2 = 32'd7;
    @(posedge clk); #2;
    E_MdOp = 3'd4; E_RD1 = 32'hDEAD;
    @(posedge clk); #2;
    E_MdStart = 0;
    w = 0;
    while (Busy && w < 64) begin
      w++;
      @(posedge clk); #2;
    end
    chk("ignore_hi", HI, 32'd0);
    chk("ignore_lo", LO, 32'd15);

    E_MdStart = 1; E_MdOp = 3'd2; E_RD1 = 32'd100; E_RD2 = 32'd7;
    @(posedge clk); #2;
    idle(3);
    reset = 1;
    @(posedge clk); #2;
    reset = 0;
    chk("midrst_busy", Busy, 0);
    chk("midrst_hi", HI, 0);
    chk("midrst_lo", LO, 0);
    idle(DC + 2);
    chk("midrst_late_hi", HI, 0);
    chk("midrst_late_lo", LO, 0);

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      E_MdStart = ($urandom_range(0, 2) == 0);
      E_MdOp    = 3'($urandom_range(0, 7));
      E_RD1     = pick();
      E_RD2     = pick();
      D_MdUse   = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    reset = 0;
    E_MdStart = 0;
    idle(DC + 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and sequences a fixed-latency operation into the HI/LO registers. It presents a `busy` status, and raises a D-stage stall request so that no HI/LO consumer or producer issues while a result is pending.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Sampled on the rising edge of `clk`.
- `E_MdStart`  in  1: E-stage instruction is a valid md operation this cycle.
- `E_MdOp`  in  3: operation code.
  - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo.
  - Other codes are no-ops.
- `E_RD1`  in  32: forwarded GRF[rs].
- `E_RD2`  in  32: forwarded GRF[rt].
- `D_MdUse`  in  1: D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `Busy`  out  1: a mult/div is in progress.
- `MdStall`  out  1: stall request to the hazard unit.
- `HI`  out  32: current HI.
- `LO`  out  32: current LO.

## Operation
State machine:
- States are IDLE and BUSY, with a down-counter `cnt` (4 bits minimum, sized for `max(MULT_CYCLES, DIV_CYCLES)`).

Reset:
- State goes to IDLE and `cnt` to 0.
- `HI` and `LO` go to 0.
- `Busy` and `MdStall` go to 0.
- Reset mid-operation abandons the operation; no HI/LO write occurs.

IDLE behaviour, when `E_MdStart` is high:
- mult/multu/div/divu:
  - Latch the op, `E_RD1` and `E_RD2`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to BUSY.
- mthi: `HI <= E_RD1` at this edge. The state stays IDLE.
- mtlo: `LO <= E_RD1` at this edge. The state stays IDLE.

BUSY behaviour:
- `cnt` decrements each cycle.
- At the edge where `cnt == 1`, write the result and return to IDLE.
- Result for mult (signed) and multu (unsigned): 64-bit product of the latched operands. `{HI, LO} <=` the product.
- Result for div (signed) and divu (unsigned): `LO <=` quotient, `HI <=` remainder.
  - Signed division truncates toward zero.
  - The remainder takes the dividend's sign.
- Division by zero: HI and LO are left unchanged. The block still spends the full `DIV_CYCLES`.
- `E_MdStart` is ignored while BUSY (any op, including mthi/mtlo). The hazard unit must prevent this case; the block must not corrupt state when it occurs.

Outputs:
- `Busy` = (state == BUSY). It is registered.
- `MdStall` = `D_MdUse & (Busy | (E_MdStart & E_MdOp <= 3))`. It is combinational.
- `HI` and `LO` are the register outputs. They read combinationally into mfhi/mflo in E.

## Timing
- `E_MdStart` is a mult/div in cycle t:
  - `Busy` is high in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at the end of cycle t+N.
  - `Busy` is low in cycle t+N+1, and the new HI/LO are visible in that cycle.
- mthi/mtlo in cycle t: the value is visible in cycle t+1. There is no busy period.
- `MdStall` rises in the same cycle as `E_MdStart` when the D-stage instruction uses HI/LO. It falls in cycle t+N+1.
- A back-to-back start in cycle t+N+1 is accepted. There are no bubbles between consecutive ops beyond the stall.
- `reset` has priority over every other input in the same cycle.

## Structure
- Shared package `mdu_pkg` holds:
  - The `E_MdOp` encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - The state encodings: MD_IDLE, MD_BUSY.
  - The default cycle counts.
- The decoder that produces `E_MdStart`, `E_MdOp` and `D_MdUse` imports the same package.
- One natural sub-module, `mdu_alu`:
  - Combinational.
  - Inputs: latched op and operands.
  - Outputs: 64-bit {hi, lo} result and a div-by-zero flag.
  - Instantiated once inside `mdu_ctrl`.

## Test plan
- **Signed mult:** reset, then mult with RD1=0xFFFFFFFF, RD2=0x00000002 → `Busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- **Unsigned mult:** multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- **Divide:**
  - div with RD1=0xFFFFFFF9 (-7), RD2=2 → `Busy` for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with 7, 2 → LO=3, HI=1.
- **Divide by zero and move-to:**
  - mthi 0x1234, then mtlo 0x5678 → each visible the next cycle, `Busy` never high.
  - divu by 0 → 10 busy cycles, then HI=0x1234, LO=0x5678 unchanged.
- **Stall behaviour:**
  - `D_MdUse`=1 held from the start cycle → `MdStall` high from the start cycle through t+N, low at t+N+1.
  - A second `E_MdStart` mult during BUSY → ignored; only the first result is written.
- **Reset mid-operation:** reset asserted in cycle 4 of a div → next cycle `Busy`=0, HI=LO=0, and no later write occurs.
